// File: rtl/cu_pkg.sv
// rtl/cu_pkg.sv - shared types and constants for the control-unit stage sequencer
package cu_pkg;

    localparam int CU_XLEN_DEFAULT = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } cu_state_e;

    // Bit positions inside halt_cause
    localparam int ERR_ALU      = 0;
    localparam int ERR_INVALID  = 1;
    localparam int ERR_ECALL    = 2;
    localparam int ERR_EBREAK   = 3;
    localparam int ERR_PC_BOUND = 4;

endpackage

// File: rtl/cu_seq_pc_next.sv
// rtl/cu_seq_pc_next.sv - next-PC select, JALR LSB clear and PC bound compare (CU_SEQ_PC_BOUND_EN)
module cu_seq_pc_next #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_LIMIT = XLEN'(512)
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] pc_increment_i,
    input  logic            pc_redirect_i,
    input  logic [XLEN-1:0] pc_target_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            bound_viol_o
);

    // Absolute targets always land on an even address; relative moves wrap mod 2^XLEN
    always_comb begin
        if (pc_redirect_i) begin
            pc_next_o = pc_target_i & ~XLEN'(1);
        end else begin
            pc_next_o = pc_i + pc_increment_i;
        end
    end

`ifdef CU_SEQ_PC_BOUND_EN
    assign bound_viol_o = (pc_next_o >= PC_LIMIT);
`else
    logic unused_limit_cmp;
    assign unused_limit_cmp = (pc_next_o >= PC_LIMIT);
    assign bound_viol_o     = 1'b0;
`endif

endmodule

// File: rtl/cu_stage_sequencer.sv
// rtl/cu_stage_sequencer.sv - N-phase instruction sequencer with stall, PC update, retire count and sticky halt (CU_SEQ_PC_BOUND_EN)
module cu_stage_sequencer
    import cu_pkg::*;
#(
    parameter int               XLEN         = CU_XLEN_DEFAULT,
    parameter int               NUM_PHASES   = 4,
    parameter int               DECODE_PHASE = 1,
    parameter logic [XLEN-1:0]  PC_RESET     = '0,
    parameter logic [XLEN-1:0]  PC_LIMIT     = XLEN'(512),
    parameter int               ERR_W        = 4,
    localparam int              PW           = $clog2(NUM_PHASES)
) (
    input  logic              soc_clk,
    input  logic              reset,
    input  logic              start,
    input  logic              idu_ready,
    input  logic              stall,
    input  logic [XLEN-1:0]   pc_increment,
    input  logic              pc_redirect,
    input  logic [XLEN-1:0]   pc_target,
    input  logic [ERR_W-1:0]  err_vec,
    output logic [PW-1:0]     phase,
    output logic [NUM_PHASES-1:0] phase_strobe,
    output logic              fetch_start,
    output logic              cu_ready,
    output logic [XLEN-1:0]   pc,
    output logic              busy,
    output logic              halted,
    output logic [ERR_W:0]    halt_cause,
    output logic [31:0]       retired_count
);

    cu_state_e         state_q, state_d;
    logic [PW-1:0]     phase_q, phase_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       retired_q, retired_d;
    logic [ERR_W:0]    cause_q, cause_d;
    logic              fetch_q, fetch_d;

    logic              run;
    logic              err_any;
    logic              dec_wait;
    logic              last_phase;
    logic              advance;
    logic              commit;
    logic [XLEN-1:0]   pc_next;
    logic              bound_viol;

    assign run        = (state_q == ST_RUN);
    assign err_any    = |err_vec;
    assign dec_wait   = (phase_q == PW'(DECODE_PHASE)) && !idu_ready;
    assign last_phase = (phase_q == PW'(NUM_PHASES - 1));
    // Error beats stall, stall beats the decode wait
    assign advance    = run && !err_any && !stall && !dec_wait;
    assign commit     = advance && last_phase;

    cu_seq_pc_next #(
        .XLEN     (XLEN),
        .PC_LIMIT (PC_LIMIT)
    ) u_pc_next (
        .pc_i           (pc_q),
        .pc_increment_i (pc_increment),
        .pc_redirect_i  (pc_redirect),
        .pc_target_i    (pc_target),
        .pc_next_o      (pc_next),
        .bound_viol_o   (bound_viol)
    );

    // State register
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: HALT is only left through reset
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (err_any) begin
                    state_d = ST_HALT;
                end else if (commit && bound_viol) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs derived from state and current inputs
    always_comb begin
        phase_strobe = '0;
        if (run) begin
            phase_strobe = NUM_PHASES'(1) << phase_q;
        end
        cu_ready = commit;
        busy     = run;
        halted   = (state_q == ST_HALT);
    end

    // Datapath next values: phase step, commit-time PC/counter update, sticky cause
    always_comb begin
        phase_d   = phase_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        if (run && err_any) begin
            cause_d[ERR_W-1:0] = cause_q[ERR_W-1:0] | err_vec;
        end
        if (advance) begin
            phase_d = last_phase ? '0 : phase_q + PW'(1);
        end
        if (commit) begin
            pc_d      = pc_next;
            retired_d = retired_q + 32'd1;
            if (bound_viol) begin
                cause_d[ERR_W] = 1'b1;
            end
        end
        // Pulse only on a fresh entry to phase 0 that stays in RUN
        fetch_d = ((state_q == ST_IDLE) && start) || (commit && !bound_viol);
    end

    // Datapath registers
    always_ff @(posedge soc_clk) begin
        if (reset) begin
            phase_q   <= '0;
            pc_q      <= PC_RESET;
            retired_q <= '0;
            cause_q   <= '0;
            fetch_q   <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
            fetch_q   <= fetch_d;
        end
    end

    assign phase         = phase_q;
    assign fetch_start   = fetch_q;
    assign pc            = pc_q;
    assign halt_cause    = cause_q;
    assign retired_count = retired_q;

endmodule

// File: tb/tb_cu_stage_sequencer.sv
// tb/tb_cu_stage_sequencer.sv - directed and randomized checks of cu_stage_sequencer against an instruction-level model
module tb_cu_stage_sequencer;

    logic        soc_clk = 1'b0;
    logic        reset, start, idu_ready, stall, pc_redirect;
    logic [31:0] pc_increment, pc_target;
    logic [3:0]  err_vec;
    logic [1:0]  phase;
    logic [3:0]  phase_strobe;
    logic        fetch_start, cu_ready, busy, halted;
    logic [31:0] pc, retired_count;
    logic [4:0]  halt_cause;

    int checks = 0;
    int passes = 0;

    // Model of the architectural behaviour
    bit          m_run, m_halt, m_fetch;
    int          m_phase;
    logic [31:0] m_pc, m_ret;
    logic [4:0]  m_cause;

    always #5 soc_clk = ~soc_clk;

    cu_stage_sequencer dut (
        .soc_clk       (soc_clk),
        .reset         (reset),
        .start         (start),
        .idu_ready     (idu_ready),
        .stall         (stall),
        .pc_increment  (pc_increment),
        .pc_redirect   (pc_redirect),
        .pc_target     (pc_target),
        .err_vec       (err_vec),
        .phase         (phase),
        .phase_strobe  (phase_strobe),
        .fetch_start   (fetch_start),
        .cu_ready      (cu_ready),
        .pc            (pc),
        .busy          (busy),
        .halted        (halted),
        .halt_cause    (halt_cause),
        .retired_count (retired_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_run = 0; m_halt = 0; m_fetch = 0; m_phase = 0;
        m_pc = 32'd0; m_ret = 32'd0; m_cause = 5'd0;
    endtask

    function automatic bit m_commit_now();
        return m_run && err_vec == 4'd0 && !stall && !(m_phase == 1 && !idu_ready) && m_phase == 3;
    endfunction

    // One clock edge of the instruction-cycle rules
    task automatic model_step();
        if (reset) begin
            model_reset();
        end else if (!m_run && !m_halt) begin
            m_fetch = start;
            if (start) begin
                m_run = 1; m_phase = 0;
            end
        end else if (m_halt) begin
            m_fetch = 0;
        end else begin
            m_fetch = 0;
            if (err_vec != 4'd0) begin
                m_run = 0; m_halt = 1;
                m_cause[3:0] = m_cause[3:0] | err_vec;
            end else if (stall || (m_phase == 1 && !idu_ready)) begin
                m_phase = m_phase;
            end else if (m_phase == 3) begin
                m_pc = pc_redirect ? {pc_target[31:1], 1'b0} : m_pc + pc_increment;
                m_ret = m_ret + 1;
                m_phase = 0;
`ifdef CU_SEQ_PC_BOUND_EN
                if (m_pc >= 32'd512) begin
                    m_run = 0; m_halt = 1; m_cause[4] = 1'b1;
                end else begin
                    m_fetch = 1;
                end
`else
                m_fetch = 1;
`endif
            end else begin
                m_phase = m_phase + 1;
            end
        end
    endtask

    task automatic check_all();
        logic [3:0] exp_strobe;
        exp_strobe = m_run ? (4'b0001 << m_phase) : 4'b0000;
        chk("phase", 64'(phase), 64'(m_phase));
        chk("phase_strobe", 64'(phase_strobe), 64'(exp_strobe));
        chk("fetch_start", 64'(fetch_start), 64'(m_fetch));
        chk("cu_ready", 64'(cu_ready), 64'(m_commit_now()));
        chk("pc", 64'(pc), 64'(m_pc));
        chk("busy", 64'(busy), 64'(m_run));
        chk("halted", 64'(halted), 64'(m_halt));
        chk("halt_cause", 64'(halt_cause), 64'(m_cause));
        chk("retired_count", 64'(retired_count), 64'(m_ret));
    endtask

    // Inputs are set at the falling edge; check, then take one rising edge
    task automatic tick();
        #1;
        check_all();
        @(posedge soc_clk);
        model_step();
        @(negedge soc_clk);
    endtask

    initial begin
        reset = 1; start = 0; idu_ready = 1; stall = 0; pc_redirect = 0;
        pc_increment = 32'd4; pc_target = 32'd0; err_vec = 4'd0;
        @(posedge soc_clk);
        @(negedge soc_clk);
        model_reset();
        tick();
        reset = 0;
        tick();
        chk("rst_pc", 64'(pc), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // Three straight instructions
        start = 1;
        tick();
        start = 0;
        chk("start_fetch", 64'(fetch_start), 64'd1);
        repeat (12) tick();
        chk("seq_pc12", 64'(pc), 64'd12);
        chk("seq_ret3", 64'(retired_count), 64'd3);

        // Two stall cycles in phase 2
        repeat (2) tick();
        stall = 1;
        tick();
        chk("stall_hold1", 64'(phase), 64'd2);
        tick();
        chk("stall_hold2", 64'(phase), 64'd2);
        stall = 0;
        repeat (2) tick();
        chk("stall_pc16", 64'(pc), 64'd16);
        chk("stall_ret4", 64'(retired_count), 64'd4);

        // Decode not ready for three cycles in phase 1
        tick();
        idu_ready = 0;
        repeat (3) begin
            tick();
            chk("idu_hold", 64'(phase), 64'd1);
            chk("idu_nofetch", 64'(fetch_start), 64'd0);
        end
        idu_ready = 1;
        repeat (3) tick();
        chk("idu_pc20", 64'(pc), 64'd20);

        // Absolute redirect with odd target
        repeat (3) tick();
        pc_redirect = 1; pc_target = 32'h0000_0105;
        tick();
        pc_redirect = 0;
        chk("redir_pc", 64'(pc), 64'h104);

        // Error in the last phase: halt with no commit, then everything ignored
        repeat (3) tick();
        err_vec = 4'b0100;
        tick();
        err_vec = 4'd0;
        chk("err_halted", 64'(halted), 64'd1);
        chk("err_cause", 64'(halt_cause), 64'h04);
        chk("err_pc", 64'(pc), 64'h104);
        chk("err_ret", 64'(retired_count), 64'd6);
        chk("err_phase", 64'(phase), 64'd3);
        repeat (5) begin
            start = 1; err_vec = 4'($urandom_range(0, 15));
            stall = 1'($urandom_range(0, 1));
            tick();
        end
        start = 0; err_vec = 4'd0; stall = 0;
        chk("err_sticky", 64'(halt_cause), 64'h04);

        // PC bound at 512
        reset = 1;
        tick();
        reset = 0; start = 1;
        tick();
        start = 0;
        repeat (3) tick();
        pc_redirect = 1; pc_target = 32'h1FC;
        tick();
        pc_redirect = 0; pc_increment = 32'd4;
        chk("bound_pc508", 64'(pc), 64'd508);
        repeat (4) tick();
        chk("bound_pc512", 64'(pc), 64'd512);
`ifdef CU_SEQ_PC_BOUND_EN
        chk("bound_halted", 64'(halted), 64'd1);
        chk("bound_cause", 64'(halt_cause), 64'h10);
`else
        chk("nobound_run", 64'(halted), 64'd0);
        repeat (4) tick();
        chk("nobound_pc516", 64'(pc), 64'd516);
`endif

        // Randomized traffic
        reset = 1;
        tick();
        for (int i = 0; i < 500; i++) begin
            reset        = ($urandom_range(0, 63) == 0) || (halted && $urandom_range(0, 5) == 0);
            start        = ($urandom_range(0, 3) == 0);
            stall        = ($urandom_range(0, 3) == 0);
            idu_ready    = ($urandom_range(0, 2) != 0);
            err_vec      = ($urandom_range(0, 49) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            pc_redirect  = ($urandom_range(0, 3) == 0);
            pc_increment = 32'($urandom_range(0, 40));
            pc_target    = 32'($urandom_range(0, 700));
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/cu_stage_sequencer.md
# cu_stage_sequencer

Parametrised control-unit sequencer that replaces the fixed 4-count per-instruction phase counter with a configurable N-phase instruction cycle. It adds stall and decode-ready handshakes, PC update (relative and JALR-style absolute redirect), a retired-instruction counter and a sticky halt-on-error state. It sits inside the control unit between the fetch/decode units and the ALU/writeback logic and drives their per-phase enables.

## Interface
Parameters:
- XLEN, 32, PC and data width
- NUM_PHASES, 4, phases per instruction cycle (>= 2)
- DECODE_PHASE, 1, phase that waits for idu_ready (< NUM_PHASES-1)
- PC_RESET, 0, PC value after reset
- PC_LIMIT, 512, exclusive upper PC bound (used only with CU_SEQ_PC_BOUND_EN)
- ERR_W, 4, error vector width

Ports:
- soc_clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  leave IDLE and begin sequencing
- idu_ready  in  1  decode result valid
- stall  in  1  hazard stall; freezes phase and PC
- pc_increment  in  XLEN  relative next-PC offset from decoder
- pc_redirect  in  1  use pc_target instead of pc + pc_increment
- pc_target  in  XLEN  absolute target (JALR)
- err_vec  in  ERR_W  [0] ALU error, [1] invalid instruction, [2] ecall, [3] ebreak
- phase  out  $clog2(NUM_PHASES)  current phase index
- phase_strobe  out  NUM_PHASES  one-hot of phase while RUN, else 0
- fetch_start  out  1  one-cycle pulse on each entry to phase 0
- cu_ready  out  1  high in the commit cycle (last phase, advancing)
- pc  out  XLEN  current PC
- busy  out  1  state == RUN
- halted  out  1  state == HALT
- halt_cause  out  ERR_W+1  sticky cause; bit ERR_W = PC bound violation
- retired_count  out  32  committed instruction count

## Operation
- States: IDLE, RUN, HALT.
- IDLE -> RUN when start is high. start is ignored in RUN and HALT.
- advance = RUN & ~stall & ~(phase == DECODE_PHASE & ~idu_ready) & ~|err_vec.
- When advance, phase increments; it wraps from NUM_PHASES-1 to 0.
- Commit = advance & phase == NUM_PHASES-1. On commit:
  - pc <= pc_redirect ? {pc_target[XLEN-1:1], 1'b0} : pc + pc_increment. Arithmetic is mod 2^XLEN; wrap is allowed.
  - retired_count increments, wrapping mod 2^32.
- Any err_vec bit high during RUN:
  - HALT on the next edge; halt_cause[ERR_W-1:0] |= err_vec.
  - No phase advance and no PC/counter update in that cycle, even if it is the last phase.
- HALT is terminal until reset. The phase value is frozen, phase_strobe = 0, and err_vec is ignored.
- Priority: reset > error > stall > idu_ready wait > advance.

## Timing
- Reset values:
  - State IDLE; phase 0; phase_strobe 0; fetch_start 0; cu_ready 0.
  - pc = PC_RESET; busy 0; halted 0; halt_cause 0; retired_count 0.
- start at edge k gives RUN and phase 0 after edge k. fetch_start is high for exactly that cycle.
- Minimum latency is NUM_PHASES cycles per instruction. Each stall cycle or missing-idu_ready cycle adds one.
- fetch_start is registered. It is asserted the cycle after the transition into phase 0 (from IDLE or wrap) and is not re-asserted while stalled in phase 0.
- cu_ready and phase_strobe are combinational from registered state and inputs. The new pc is visible the cycle after cu_ready.
- pc_increment, pc_redirect and pc_target are sampled only in the commit cycle.
- Reset mid-instruction discards the instruction; there is no partial PC update.

## Configuration
- CU_SEQ_PC_BOUND_EN defined:
  - At commit, if next PC >= PC_LIMIT (unsigned), the PC is still written.
  - The block then enters HALT on the same edge with halt_cause[ERR_W] = 1.
- Not defined: no bound check, and halt_cause[ERR_W] is tied to 0.

## Structure
- Package cu_pkg holds:
  - the state enum (IDLE/RUN/HALT)
  - error bit index localparams (ERR_ALU=0, ERR_INVALID=1, ERR_ECALL=2, ERR_EBREAK=3, ERR_PC_BOUND=4)
  - the default XLEN
- One sub-module, cu_seq_pc_next: combinational next-PC select, LSB clear and bound compare.

## Test plan
- Reset, start, idu_ready=1, pc_increment=4, 3 instructions, NUM_PHASES=4:
  - fetch_start pulses every 4 cycles.
  - pc goes 0→4→8→12; retired_count=3.
- stall high for 2 cycles in phase 2 -> the instruction takes 6 cycles, with phase held at 2 during the stall.
- idu_ready low for 3 cycles in phase 1 -> phase held at 1 and fetch_start not re-pulsed; commit occurs 3 cycles late.
- pc_redirect=1, pc_target=0x0000_0105 at commit -> pc=0x104.
- err_vec=4'b0100 in phase 3 with stall=0 -> HALT, halt_cause=5'b00100, pc unchanged, retired_count unchanged; later inputs are ignored.
- CU_SEQ_PC_BOUND_EN, pc=508, pc_increment=4 -> pc=512, halted=1, halt_cause[4]=1. Without the macro, the bench continues to 516.
